// File: rtl/seg7_pkg.sv
// Shared segment glyphs and width helper for the multiplexed
// 7-segment display driver.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h18;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Never returns 0 so counters of size 1 still get a real bit.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational BCD/hex nibble to active-low {g..a} segment decoder
// with a forced-blank input.
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_mode,
    input  logic       blank,
    output logic [6:0] seg
);

    logic [6:0] glyph;

    always_comb begin
        glyph = SEG_BLANK;
        case (code)
            4'h0: glyph = SEG_0;
            4'h1: glyph = SEG_1;
            4'h2: glyph = SEG_2;
            4'h3: glyph = SEG_3;
            4'h4: glyph = SEG_4;
            4'h5: glyph = SEG_5;
            4'h6: glyph = SEG_6;
            4'h7: glyph = SEG_7;
            4'h8: glyph = SEG_8;
            4'h9: glyph = SEG_9;
            4'hA: glyph = SEG_A;
            4'hB: glyph = SEG_B;
            4'hC: glyph = SEG_C;
            4'hD: glyph = SEG_D;
            4'hE: glyph = SEG_E;
            default: glyph = SEG_F;
        endcase
    end

    assign seg = (blank || (!hex_mode && code > 4'd9)) ? SEG_BLANK : glyph;

endmodule

// File: rtl/bcd_7seg_scan.sv
// Multiplexed multi-digit BCD display driver: shadow register,
// refresh prescaler, digit scan, leading-zero blanking, output regs.
module bcd_7seg_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter bit HEX_MODE    = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  load,
    input  logic                  lzb,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  scan_tick
);

    localparam int IW = clog2(DIGITS);
    localparam int PW = clog2(REFRESH_DIV);

    logic [4*DIGITS-1:0] shadow_q, shadow_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                tick_q, tick_d;

    logic                wrap;
    logic [3:0]          nib;
    logic                blank;
    logic                zero_above;

    assign wrap     = (pre_q == PW'(REFRESH_DIV - 1));
    assign pre_d    = wrap ? '0 : pre_q + 1'b1;
    assign shadow_d = load ? bcd : shadow_q;

    always_comb begin
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // Walk from the top digit down so zero_above covers nibbles k..DIGITS-1.
    always_comb begin
        nib        = 4'd0;
        blank      = 1'b0;
        zero_above = 1'b1;
        an_d       = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (shadow_q[4*k +: 4] == 4'd0);
            if (idx_q == IW'(k)) begin
                nib     = shadow_q[4*k +: 4];
                blank   = lzb && (k > 0) && zero_above;
                an_d[k] = 1'b0;
            end
        end
    end

    seg7_digit_decode u_dec (
        .code     (nib),
        .hex_mode (HEX_MODE),
        .blank    (blank),
        .seg      (seg_d)
    );

    // Prescaler at zero means the output regs now show a freshly selected digit.
    assign tick_d = (pre_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            pre_q    <= '0;
            idx_q    <= '0;
            seg_q    <= SEG_BLANK;
            an_q     <= '1;
            tick_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            tick_q   <= tick_d;
        end
    end

    assign seg       = seg_q;
    assign an        = an_q;
    assign scan_tick = tick_q;

endmodule

// File: tb/tb_bcd_7seg_scan.sv
// Bench for bcd_7seg_scan: three instances (div 4 dec, div 4 hex,
// div 1 dec) checked each edge against an arithmetic reference model.
module tb_bcd_7seg_scan;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] bcd;
    logic        load;
    logic        lzb;

    logic [6:0] seg_a, seg_b, seg_c;
    logic [3:0] an_a, an_b, an_c;
    logic       tick_a, tick_b, tick_c;

    int checks   = 0;
    int failures = 0;

    // Reference state: shadow value and edges since reset release.
    int unsigned m_shadow;
    int          m_n;

    logic [6:0] tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                             7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03,
                             7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    bcd_7seg_scan #(.DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1'b0)) dut_a (
        .clk(clk), .reset(reset), .bcd(bcd), .load(load), .lzb(lzb),
        .seg(seg_a), .an(an_a), .scan_tick(tick_a)
    );

    bcd_7seg_scan #(.DIGITS(4), .REFRESH_DIV(4), .HEX_MODE(1'b1)) dut_b (
        .clk(clk), .reset(reset), .bcd(bcd), .load(load), .lzb(lzb),
        .seg(seg_b), .an(an_b), .scan_tick(tick_b)
    );

    bcd_7seg_scan #(.DIGITS(4), .REFRESH_DIV(1), .HEX_MODE(1'b0)) dut_c (
        .clk(clk), .reset(reset), .bcd(bcd), .load(load), .lzb(lzb),
        .seg(seg_c), .an(an_c), .scan_tick(tick_c)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] ref_seg(input int unsigned v, input int d,
                                           input bit z, input bit hex);
        int unsigned upper;
        int unsigned nb;
        upper = v >> (4 * d);
        nb    = upper & 15;
        if (z && d > 0 && upper == 0) return 7'h7F;
        if (!hex && nb > 9) return 7'h7F;
        return tab[nb];
    endfunction

    task automatic check_dut(input string nm, input int div, input bit hex,
                             input logic [6:0] s, input logic [3:0] a,
                             input logic t);
        int d;
        if (reset) begin
            chk({nm, "_rst_seg"}, {1'b0, s}, 8'h7F);
            chk({nm, "_rst_an"}, {4'h0, a}, 8'h0F);
            chk({nm, "_rst_tick"}, {7'h0, t}, 8'h00);
        end else begin
            d = (m_n / div) % 4;
            chk({nm, "_seg"}, {1'b0, s}, {1'b0, ref_seg(m_shadow, d, lzb, hex)});
            chk({nm, "_an"}, {4'h0, a}, {4'h0, ~(4'b0001 << d)});
            chk({nm, "_tick"}, {7'h0, t}, {7'h0, (m_n % div) == 0});
        end
    endtask

    // One clock edge: compare against the pre-edge model, then advance it.
    task automatic step();
        @(posedge clk);
        #1;
        check_dut("a", 4, 1'b0, seg_a, an_a, tick_a);
        check_dut("b", 4, 1'b1, seg_b, an_b, tick_b);
        check_dut("c", 1, 1'b0, seg_c, an_c, tick_c);
        if (reset) begin
            m_n      = 0;
            m_shadow = 0;
        end else begin
            m_n++;
            if (load) m_shadow = bcd;
        end
    endtask

    task automatic load_val(input logic [15:0] v, input int cycles);
        bcd  = v;
        load = 1'b1;
        step();
        load = 1'b0;
        bcd  = 16'($urandom);
        for (int i = 0; i < cycles; i++) step();
    endtask

    initial begin
        m_shadow = 0;
        m_n      = 0;
        reset    = 1'b1;
        bcd      = 16'hFFFF;
        load     = 1'b1;
        lzb      = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        load  = 1'b0;
        step();
        chk("first_an", {4'h0, an_a}, 8'h0E);
        chk("first_seg", {1'b0, seg_a}, 8'h40);
        for (int i = 0; i < 3; i++) step();

        load_val(16'h1234, 16);
        lzb = 1'b1;
        load_val(16'h0040, 16);
        load_val(16'h0000, 16);
        lzb = 1'b0;
        load_val(16'hABCF, 16);

        while ((m_n % 16) != 15) step();
        bcd  = 16'h0009;
        load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("wrap_load_an", {4'h0, an_a}, 8'h0E);
        chk("wrap_load_seg", {1'b0, seg_a}, 8'h18);

        while (((m_n / 4) % 4) != 2) step();
        reset = 1'b1;
        step();
        chk("midframe_rst_an", {4'h0, an_a}, 8'h0F);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step();

        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0: bcd = 16'($urandom_range(0, 15));
                1: bcd = 16'($urandom_range(0, 255));
                default: bcd = 16'($urandom);
            endcase
            load  = ($urandom_range(0, 3) == 0);
            lzb   = ($urandom_range(0, 7) != 0) ? lzb : ~lzb;
            reset = ($urandom_range(0, 63) == 0);
            step();
        end
        reset = 1'b0;
        load  = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
